// File: rtl/offchip_sram_bridge.sv
// offchip_sram_bridge: serves 16-bit word requests from the memory controller using an
// external SPI serial SRAM (sequential mode, 24-bit byte address). One request at a time.
// Each request becomes one 48-bit SPI mode-0 frame: command, address, data.

module offchip_sram_bridge #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        mem_ready,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        sram_cs_n,
    output logic        sram_sck,
    output logic        sram_mosi,
    input  logic        sram_miso
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PhLast = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_t;

    state_t        state_q;
    logic [PW-1:0] phase_q;
    logic [5:0]    bit_cnt_q;
    logic [47:0]   frame_sh_q;
    logic [15:0]   rdata_sh_q;
    logic          is_read_q;

    logic [47:0]   frame_new;
    logic          phase_end;

    // Frame for the request on the inputs: command, byte address (2 x word), data.
    always_comb begin
        frame_new = {(req_we ? 8'h02 : 8'h03), 7'b0, req_addr, 1'b0,
                     (req_we ? req_wdata : 16'h0000)};
    end

    assign phase_end = (phase_q == PhLast);

    // Single FSM: sequences SETUP / SHIFT / GAP and drives every output from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            bit_cnt_q   <= 6'd0;
            frame_sh_q  <= 48'h0;
            rdata_sh_q  <= 16'h0;
            is_read_q   <= 1'b0;
            mem_ready   <= 1'b0;
            rdata       <= 16'h0;
            rdata_valid <= 1'b0;
            sram_cs_n   <= 1'b1;
            sram_sck    <= 1'b0;
            sram_mosi   <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sram_cs_n <= 1'b1;
                    sram_sck  <= 1'b0;
                    sram_mosi <= 1'b0;
                    if (mem_ready && req_valid) begin
                        frame_sh_q <= frame_new;
                        is_read_q  <= ~req_we;
                        sram_cs_n  <= 1'b0;
                        sram_mosi  <= frame_new[47];
                        mem_ready  <= 1'b0;
                        phase_q    <= '0;
                        state_q    <= StSetup;
                    end else begin
                        mem_ready <= 1'b1;
                    end
                end
                StSetup: begin
                    sram_mosi <= frame_sh_q[47];
                    if (phase_end) begin
                        phase_q   <= '0;
                        bit_cnt_q <= 6'd47;
                        sram_sck  <= 1'b1;
                        state_q   <= StShift;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StShift: begin
                    if (!phase_end) begin
                        phase_q <= phase_q + 1'b1;
                    end else begin
                        phase_q <= '0;
                        if (sram_sck) begin
                            // End of high phase: sample MISO, fall SCK, launch next MOSI bit.
                            rdata_sh_q <= {rdata_sh_q[14:0], sram_miso};
                            sram_sck   <= 1'b0;
                            if (bit_cnt_q != 6'd0) begin
                                frame_sh_q <= {frame_sh_q[46:0], 1'b0};
                                sram_mosi  <= frame_sh_q[46];
                            end else begin
                                // Low phase of the last bit doubles as the CS hold time.
                                sram_mosi <= 1'b0;
                            end
                        end else if (bit_cnt_q == 6'd0) begin
                            sram_cs_n <= 1'b1;
                            state_q   <= StGap;
                            if (is_read_q) begin
                                rdata       <= rdata_sh_q;
                                rdata_valid <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 6'd1;
                            sram_sck  <= 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (phase_end) begin
                        phase_q   <= '0;
                        mem_ready <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_offchip_sram_bridge.sv
// Bench for offchip_sram_bridge: directed vector table, multi-cycle corner sequences and
// randomized traffic against a word-level reference memory, with a byte-level SPI SRAM model.

module tb_offchip_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        mem_ready, rdata_valid, sram_cs_n, sram_sck, sram_mosi;
    logic        sram_miso = 1'b0;
    logic [15:0] rdata;

    logic        r1_valid, r1_we;
    logic [15:0] r1_addr, r1_wdata;
    logic        r1_ready, r1_rv, r1_cs_n, r1_sck, r1_mosi;
    logic        r1_miso = 1'b0;
    logic [15:0] r1_rdata;

    offchip_sram_bridge #(.CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .mem_ready(mem_ready), .rdata(rdata), .rdata_valid(rdata_valid),
        .sram_cs_n(sram_cs_n), .sram_sck(sram_sck), .sram_mosi(sram_mosi),
        .sram_miso(sram_miso)
    );

    offchip_sram_bridge #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(r1_valid), .req_we(r1_we), .req_addr(r1_addr),
        .req_wdata(r1_wdata), .mem_ready(r1_ready), .rdata(r1_rdata), .rdata_valid(r1_rv),
        .sram_cs_n(r1_cs_n), .sram_sck(r1_sck), .sram_mosi(r1_mosi), .sram_miso(r1_miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference memory: word-granular; unwritten words come from the SRAM power-up pattern.
    bit [7:0]    sram_mem [int];
    logic [15:0] ref_mem  [int];

    function automatic bit [7:0] init_byte(input int a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic bit [7:0] sram_byte(input int a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] wa);
        int a;
        a = int'(wa);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {init_byte(2 * a), init_byte(2 * a + 1)};
    endfunction

    // SPI SRAM model (mode 0, sequential): edges detected on the falling clk edge.
    int          nbits = 0;
    logic [47:0] shin = '0;
    logic [7:0]  m_cmd = '0;
    int          m_addr = 0;
    logic [47:0] last_frame = '0;
    int          last_nbits = 0;
    logic [47:0] frames_q[$];
    logic        p_cs = 1'b1, p_sck = 1'b0;

    always @(negedge clk) begin
        int k;
        bit [7:0] b;
        if (p_cs === 1'b1 && sram_cs_n === 1'b0) begin
            nbits = 0;
            shin  = '0;
        end
        if (sram_cs_n === 1'b0 && p_sck === 1'b0 && sram_sck === 1'b1) begin
            shin = {shin[46:0], sram_mosi};
            nbits++;
            if (nbits == 32) begin
                m_cmd  = shin[31:24];
                m_addr = int'({8'h00, shin[23:0]});
            end
        end
        if (sram_cs_n === 1'b0 && p_sck === 1'b1 && sram_sck === 1'b0 && nbits >= 32 &&
            nbits < 48 && m_cmd == 8'h03) begin
            k = nbits - 32;
            b = sram_byte(m_addr + k / 8);
            sram_miso = b[7 - k % 8];
        end
        if (p_cs === 1'b0 && sram_cs_n === 1'b1) begin
            last_nbits = nbits;
            if (nbits == 48) begin
                last_frame = shin;
                frames_q.push_back(shin);
                if (shin[47:40] == 8'h02) begin
                    sram_mem[m_addr]     = shin[15:8];
                    sram_mem[m_addr + 1] = shin[7:0];
                end
            end
        end
        p_cs  = sram_cs_n;
        p_sck = sram_sck;
    end

    // Frame monitor for the CLK_DIV=1 instance.
    int          n1 = 0;
    logic [47:0] f1 = '0;
    logic        p1_cs = 1'b1, p1_sck = 1'b0;

    always @(negedge clk) begin
        if (p1_cs === 1'b1 && r1_cs_n === 1'b0) begin
            n1 = 0;
            f1 = '0;
        end
        if (r1_cs_n === 1'b0 && p1_sck === 1'b0 && r1_sck === 1'b1) begin
            f1 = {f1[46:0], r1_mosi};
            n1++;
        end
        p1_cs  = r1_cs_n;
        p1_sck = r1_sck;
    end

    // One complete request on the CLK_DIV=2 instance, checked against fixed cycle numbers.
    task automatic run_txn(input logic we, input logic [15:0] a, input logic [15:0] wd,
                           input logic [47:0] exp_frame, input logic [15:0] exp_rd,
                           input string tag);
        int cs_last, rv_n, rv_cyc, rdy;
        cs_last = -1; rv_n = 0; rv_cyc = -1; rdy = -1;
        for (int w = 0; w < 400 && mem_ready !== 1'b1; w++) tick();
        chk({tag, ".ready_before"}, mem_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        tick();
        req_valid = 1'b0; req_we = ~we; req_addr = ~a; req_wdata = ~wd;
        for (int c = 1; c <= 300; c++) begin
            if (c == 1) chk({tag, ".cycle1_ready_cs"}, {mem_ready, sram_cs_n}, 2'b00);
            if (sram_cs_n === 1'b0) cs_last = c;
            if (rdata_valid === 1'b1) begin rv_n++; rv_cyc = c; end
            if (mem_ready === 1'b1) begin rdy = c; break; end
            tick();
        end
        chk({tag, ".cs_last"}, cs_last, 194);
        chk({tag, ".ready_cycle"}, rdy, 197);
        chk({tag, ".sck_rises"}, last_nbits, 48);
        chk({tag, ".frame"}, last_frame, exp_frame);
        chk({tag, ".rv_count"}, rv_n, we ? 0 : 1);
        if (!we) begin
            chk({tag, ".rv_cycle"}, rv_cyc, 195);
            chk({tag, ".rdata"}, rdata, exp_rd);
        end else begin
            ref_mem[int'(a)] = wd;
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [47:0] frame;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int min_gap, hi_run, rv_seen, cs_last, rdy, sck_bad, rv1;
        logic seen_low;
        logic [47:0] fr;
        logic we;
        logic [15:0] a, wd;

        vecs[0] = '{1'b1, 16'h1234, 16'hBEEF, 48'h02_002468_BEEF, 16'h0000};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 48'h03_000020_0000, 16'hA55A};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 48'h03_01FFFE_0000, 16'h1234};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hC3A5, 48'h02_01FFFE_C3A5, 16'h0000};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 48'h03_01FFFE_0000, 16'hC3A5};
        vecs[5] = '{1'b0, 16'h1234, 16'h0000, 48'h03_002468_0000, 16'hBEEF};

        sram_mem[32] = 8'hA5;  sram_mem[33] = 8'h5A;  ref_mem[16'h0010] = 16'hA55A;
        sram_mem[32'h1FFFE] = 8'h12;  sram_mem[32'h1FFFF] = 8'h34;
        ref_mem[16'hFFFF] = 16'h1234;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        r1_valid = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        repeat (3) tick();
        chk("reset.mem_ready", mem_ready, 1'b0);
        chk("reset.rdata", rdata, 16'h0000);
        chk("reset.rdata_valid", rdata_valid, 1'b0);
        chk("reset.spi_pins", {sram_cs_n, sram_sck, sram_mosi}, 3'b100);
        rst = 1'b0;
        tick();
        chk("reset.ready_rise", {mem_ready, r1_ready}, 2'b11);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].frame, vecs[i].rd,
                    $sformatf("vec%0d", i));
        end

        // Reset in the middle of a read.
        for (int w = 0; w < 400 && mem_ready !== 1'b1; w++) tick();
        rv_seen = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c < 60; c++) begin
            if (rdata_valid === 1'b1) rv_seen++;
            tick();
        end
        chk("rstmid.rdata_held", rdata, 16'hBEEF);
        rst = 1'b1;
        tick();
        chk("rstmid.pins", {sram_cs_n, sram_sck}, 2'b10);
        chk("rstmid.rdata_clear", rdata, 16'h0000);
        chk("rstmid.no_valid", {rv_seen[0], rdata_valid, mem_ready}, 3'b000);
        rst = 1'b0;
        tick();
        chk("rstmid.ready_after", mem_ready, 1'b1);
        run_txn(1'b0, 16'h0010, 16'h0000, 48'h03_000020_0000, ref_read(16'h0010), "rstmid.rd");

        // req_valid held high with a changing address: only cycles 0, 197, 394 are issued.
        frames_q.delete();
        min_gap = 1000; hi_run = 0; seen_low = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0400;
        for (int k = 1; k <= 590; k++) begin
            tick();
            req_addr = 16'h0400 + 16'(k);
            if (sram_cs_n === 1'b1) begin
                hi_run++;
            end else begin
                if (seen_low && hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
                hi_run = 0;
                seen_low = 1'b1;
            end
        end
        req_valid = 1'b0;
        chk("b2b.frame_count", frames_q.size(), 3);
        for (int j = 0; j < 3 && j < frames_q.size(); j++) begin
            fr = frames_q[j];
            chk($sformatf("b2b.addr%0d", j), fr[32:17], 16'h0400 + 16'(197 * j));
        end
        chk("b2b.cs_gap_ge2", (min_gap >= 2 && min_gap < 1000) ? 1'b1 : 1'b0, 1'b1);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 12; i++) begin
            we = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: a = 16'h0000;
                1: a = 16'hFFFF;
                2: a = 16'h1234;
                default: a = 16'h0800 + 16'($urandom_range(0, 3));
            endcase
            wd = 16'($urandom);
            run_txn(we, a, wd, {(we ? 8'h02 : 8'h03), 7'b0, a, 1'b0, (we ? wd : 16'h0000)},
                    ref_read(a), $sformatf("rand%0d", i));
        end

        // CLK_DIV=1: SCK toggles every cycle, ready again at cycle 99.
        for (int w = 0; w < 400 && r1_ready !== 1'b1; w++) tick();
        cs_last = -1; rdy = -1; sck_bad = 0; rv1 = 0;
        r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 16'h00FF; r1_wdata = 16'h5A0F;
        tick();
        r1_valid = 1'b0; r1_addr = 16'h0000; r1_wdata = 16'h0000;
        for (int c = 1; c <= 150; c++) begin
            if (c == 1) chk("div1.cycle1_ready_cs", {r1_ready, r1_cs_n}, 2'b00);
            if (c >= 2 && c <= 97 && r1_sck !== ((c % 2 == 0) ? 1'b1 : 1'b0)) sck_bad++;
            if (r1_cs_n === 1'b0) cs_last = c;
            if (r1_rv === 1'b1) rv1++;
            if (r1_ready === 1'b1) begin rdy = c; break; end
            tick();
        end
        chk("div1.sck_toggle_errors", sck_bad, 0);
        chk("div1.cs_last", cs_last, 97);
        chk("div1.ready_cycle", rdy, 99);
        chk("div1.sck_rises", n1, 48);
        chk("div1.frame", f1, 48'h02_0001FE_5A0F);
        chk("div1.no_valid", rv1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/offchip_sram_bridge.md
# offchip_sram_bridge

Off-chip memory responder that serves the memory controller's 16-bit word requests using an external SPI serial SRAM (23LC1024-class, 128 KB, 24-bit byte address, sequential mode).
- Accepts one read or write request at a time.
- Serialises it as one SPI mode-0 transaction.
- Returns read data with a one-cycle valid strobe.
- Raises `mem_ready` again only when it can take the next request.

## Interface

Parameters
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles. Legal range is ≥1.

Ports
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request strobe. It is accepted only in a cycle where `mem_ready`=1.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  write data.
- `mem_ready`  out  1  bridge is idle and can accept a request.
- `rdata`  out  16  last read word.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` is updated.
- `sram_cs_n`  out  1  SPI chip select, active low.
- `sram_sck`  out  1  SPI clock, mode 0.
- `sram_mosi`  out  1  SPI data to the SRAM.
- `sram_miso`  in  1  SPI data from the SRAM.

## Operation

Handshake
- A request is accepted on a rising edge where `req_valid`=1 and `mem_ready`=1.
- At acceptance, `req_we`, `req_addr` and `req_wdata` are captured into a 48-bit shift register. Later changes on those inputs are ignored.
- `req_valid` while busy is ignored. Requests are not queued.

Frame, shifted MSB first
- Byte 0, command: 0x02 for a write, 0x03 for a read.
- Bytes 1–3, address: {7'b0, req_addr, 1'b0}, i.e. byte address = 2 × word address.
- Bytes 4–5, data: for writes, `req_wdata`[15:8] then [7:0]. For reads, 16 don't-care bits; MOSI drives 0.

Read data
- Big-endian: the high byte is stored at the lower byte address.
- MISO bits shift into `rdata_sh` MSB first during the last 16 bit-times.
- `rdata` ← `rdata_sh` when the frame ends.

States
- IDLE
  - Outputs: `cs_n`=1, `sck`=0, `mosi`=0, `mem_ready`=1.
  - Exit: on acceptance → SETUP.
- SETUP
  - Duration: `CLK_DIV` cycles.
  - Outputs: `cs_n`=0, `sck`=0, `mosi`=frame bit 47.
- SHIFT, 48 bit-times
  - Each bit-time is a high phase of `CLK_DIV` cycles (`sck`=1) followed by a low phase of `CLK_DIV` cycles (`sck`=0).
  - MISO is sampled on the last cycle of each high phase.
  - MOSI advances to the next frame bit on the first cycle of each low phase, except after bit 0.
  - The low phase of bit 0 is the CS hold. `mosi`=0 in it.
- GAP
  - Duration: `CLK_DIV` cycles. Outputs: `cs_n`=1, `sck`=0.
  - On its first cycle: `rdata_valid`=1 for reads, and `rdata` is loaded.
  - Exit: → IDLE.

Counters
- Phase counter is ⌈log2(CLK_DIV)⌉ bits (minimum 1 bit) and counts 0..CLK_DIV-1.
- Bit counter is 6 bits and counts 47..0.
- No wrap-around within a frame. Word address 0xFFFF maps to byte address 0x01FFFE, with no overflow into bit 17.

Reset
- Reset values: `mem_ready`=0, `rdata`=0, `rdata_valid`=0, `sram_cs_n`=1, `sram_sck`=0, `sram_mosi`=0; state = IDLE.
- `mem_ready` rises on the first edge with `rst`=0.
- Reset mid-frame abandons the transfer immediately. No `rdata_valid` is produced, and `rdata` is cleared.

## Timing

All cycle numbers are counted from acceptance edge = cycle 0, so the first cycle after acceptance is cycle 1.
- Cycle 1: `mem_ready`=0, `cs_n`=0.
- SETUP: cycles 1..CLK_DIV.
- SHIFT: cycles CLK_DIV+1 .. 97·CLK_DIV.
- GAP: cycles 97·CLK_DIV+1 .. 98·CLK_DIV.
- `rdata_valid` is high in cycle 97·CLK_DIV+1 only.
- `mem_ready`=1 again in cycle 98·CLK_DIV+1.
- With `CLK_DIV`=2 the bridge is busy for 196 cycles, and the next request can be accepted at cycle 197.
- All outputs are registered. There is no combinational path from inputs to outputs.
- MISO sampling point: the SRAM launches MISO on the SCK falling edge, and the bridge samples it a full high phase after the following rising edge. This gives ≥`CLK_DIV` cycles of setup.

## Test plan

- **Write, `CLK_DIV`=2.** Stimulus: write 0xBEEF to 0x1234. Required: MOSI bytes 02 00 24 68 BE EF; exactly 48 SCK rising edges; `cs_n` low from cycle 1 to 194; `mem_ready` high at cycle 197; no `rdata_valid`.
- **Read.** Stimulus: read 0x0010, SPI model returns 0xA55A. Required: MOSI bytes 03 00 00 20; `rdata_valid` pulses once at cycle 195; `rdata`=0xA55A.
- **Top-of-memory boundary.** Stimulus: read 0xFFFF. Required: address bytes 01 FF FE. Stimulus: write then read 0xFFFF through the SRAM model. Required: data round-trips.
- **Busy behaviour and back-to-back.** Stimulus: `req_valid` held high continuously with changing `req_addr`. Required: only the addresses present at cycles 0, 197, 394 are issued; `cs_n` is high ≥2 cycles between frames.
- **Reset mid-frame.** Stimulus: `rst` pulsed at cycle 60 of a read. Required: next cycle `cs_n`=1, `sck`=0, `rdata`=0, no `rdata_valid`; `mem_ready`=1 on the cycle after `rst` falls; a following read completes correctly.
- **`CLK_DIV`=1.** Stimulus: a write. Required: SCK toggles every cycle; busy 98 cycles; `mem_ready` high at cycle 99.
